// File: rtl/vgm_pkg.sv
// rtl/vgm_pkg.sv - VGM opcode constants, wait constants and sequencer state type
package vgm_pkg;

  localparam logic [7:0] OP_YM3812  = 8'h5A;
  localparam logic [7:0] OP_WAIT_N  = 8'h61;
  localparam logic [7:0] OP_WAIT_60 = 8'h62;
  localparam logic [7:0] OP_WAIT_50 = 8'h63;
  localparam logic [7:0] OP_END     = 8'h66;
  localparam logic [3:0] OP_WAIT_SHORT = 4'h7;

  localparam int unsigned WAIT_60_N = 735;
  localparam int unsigned WAIT_50_N = 882;

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_ARG  = 3'd1,
    S_WR   = 3'd2,
    S_GAP  = 3'd3,
    S_WAIT = 3'd4,
    S_HALT = 3'd5
  } state_t;

  function automatic logic is_wait_short(input logic [7:0] op);
    return op[7:4] == OP_WAIT_SHORT;
  endfunction

endpackage

// File: rtl/vgm_wait_timer.sv
// rtl/vgm_wait_timer.sv - loadable sample-wait down-counter with tick enable
module vgm_wait_timer #(
  parameter int WAIT_W = 16
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_load,
  input  logic [WAIT_W-1:0] in_load_val,
  input  logic              in_en,
  output logic              out_zero,
  output logic              out_expire
);

  localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

  logic [WAIT_W-1:0] count_q;

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      count_q <= '0;
    end else if (in_load) begin
      count_q <= in_load_val;
    end else if (in_en && (count_q != '0)) begin
      count_q <= count_q - CNT_ONE;
    end
  end

  assign out_zero   = (count_q == '0);
  // Expiry is the tick that consumes the last remaining count.
  assign out_expire = in_en && (count_q == CNT_ONE);

endmodule

// File: rtl/vgm_opl_writer.sv
// rtl/vgm_opl_writer.sv - VGM byte-stream sequencer driving the OPL2 register-write port
module vgm_opl_writer
  import vgm_pkg::*;
#(
  parameter int WR_HOLD = 4,
  parameter int WR_GAP  = 4,
  parameter int WAIT_W  = 16
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       out_ready,
  input  logic       in_tick,
  output logic [7:0] out_reg,
  output logic [7:0] out_val,
  output logic       out_wr,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_err
);

  localparam int PH_MAX = (WR_HOLD > WR_GAP) ? WR_HOLD : WR_GAP;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(WR_HOLD - 1);
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(WR_GAP - 1);
  localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);

  state_t            state, state_nxt;
  logic [7:0]        op_q, arg0_q, reg_q, val_q;
  logic              arg_idx_q;
  logic [PH_W-1:0]   phase_q;
  logic              done_q, err_q;

  logic              xfer;
  logic              take_op, take_arg0, latch_wr, set_done, set_err;
  logic              wt_load, wt_en, wt_zero, wt_expire;
  logic [WAIT_W-1:0] wt_load_val, wait_n_trunc;
  logic [4:0]        short_n;

  assign out_ready    = (state == S_OP) || (state == S_ARG);
  assign out_busy     = !((state == S_OP) || (state == S_HALT));
  assign out_wr       = (state == S_WR);
  assign out_reg      = reg_q;
  assign out_val      = val_q;
  assign out_done     = done_q;
  assign out_err      = err_q;

  assign xfer         = in_valid && out_ready;
  assign wt_en        = in_tick && (state == S_WAIT);
  assign short_n      = {1'b0, in_data[3:0]} + 5'd1;
  // Little-endian 16-bit wait, cut to the counter width.
  assign wait_n_trunc = WAIT_W'({in_data, arg0_q});

  vgm_wait_timer #(
    .WAIT_W(WAIT_W)
  ) u_wait_timer (
    .in_clk      (in_clk),
    .in_rst_n    (in_rst_n),
    .in_load     (wt_load),
    .in_load_val (wt_load_val),
    .in_en       (wt_en),
    .out_zero    (wt_zero),
    .out_expire  (wt_expire)
  );

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state <= S_OP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    take_op     = 1'b0;
    take_arg0   = 1'b0;
    latch_wr    = 1'b0;
    set_done    = 1'b0;
    set_err     = 1'b0;
    wt_load     = 1'b0;
    wt_load_val = '0;

    case (state)
      S_OP: begin
        if (xfer) begin
          take_op = 1'b1;
          case (in_data)
            OP_YM3812, OP_WAIT_N: state_nxt = S_ARG;
            OP_WAIT_60: begin
              wt_load     = 1'b1;
              wt_load_val = WAIT_W'(WAIT_60_N);
              state_nxt   = S_WAIT;
            end
            OP_WAIT_50: begin
              wt_load     = 1'b1;
              wt_load_val = WAIT_W'(WAIT_50_N);
              state_nxt   = S_WAIT;
            end
            OP_END: begin
              set_done  = 1'b1;
              state_nxt = S_HALT;
            end
            default: begin
              if (is_wait_short(in_data)) begin
                wt_load     = 1'b1;
                wt_load_val = WAIT_W'(short_n);
                state_nxt   = S_WAIT;
              end else begin
                set_err   = 1'b1;
                state_nxt = S_HALT;
              end
            end
          endcase
        end
      end
      S_ARG: begin
        if (xfer) begin
          if (!arg_idx_q) begin
            take_arg0 = 1'b1;
          end else if (op_q == OP_YM3812) begin
            latch_wr  = 1'b1;
            state_nxt = S_WR;
          end else if (wait_n_trunc == '0) begin
            state_nxt = S_OP;
          end else begin
            wt_load     = 1'b1;
            wt_load_val = wait_n_trunc;
            state_nxt   = S_WAIT;
          end
        end
      end
      S_WR: begin
        if (phase_q == HOLD_LAST) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (phase_q == GAP_LAST) state_nxt = S_OP;
      end
      S_WAIT: begin
        if (wt_expire || wt_zero) state_nxt = S_OP;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_OP;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      op_q      <= '0;
      arg0_q    <= '0;
      arg_idx_q <= 1'b0;
      reg_q     <= '0;
      val_q     <= '0;
      phase_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (take_op) begin
        op_q      <= in_data;
        arg_idx_q <= 1'b0;
      end
      if (take_arg0) begin
        arg0_q    <= in_data;
        arg_idx_q <= 1'b1;
      end
      // Address and data move together with the strobe rise and then hold.
      if (latch_wr) begin
        reg_q <= arg0_q;
        val_q <= in_data;
      end
      if (state_nxt != state) begin
        phase_q <= '0;
      end else if ((state == S_WR) || (state == S_GAP)) begin
        phase_q <= phase_q + PH_ONE;
      end
      if (set_done) done_q <= 1'b1;
      if (set_err)  err_q  <= 1'b1;
    end
  end

endmodule
